// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the pipeline memory stage: stalls for LATENCY cycles, then returns load data.
// Optional build macro DMEM_MISALIGN_EN flags misaligned word accesses, suppressing the store and zeroing the read data.
//
// state | meaning
// IDLE  | waiting for ReqM; accepting a request raises CStall in the same cycle
// BUSY  | access in flight; counter counts down to the response
// DONE  | RValid pulse; a store commits on the clock edge that ends this state
module dmem_responder #(
   parameter int LATENCY   = 3,
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ReqM,
   input  logic        WeM,
   input  logic        ByteAddressM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WDataM,
   output logic        CStall,
   output logic        RValid,
   output logic [31:0] RDataW,
   output logic        MisalignErr
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   accept, finish;

   logic                   we_q, byte_q, mis_q;
   logic [ADDR_BITS+1:0]   addr_q;
   logic [31:0]            wdata_q;

   logic                   acc_we, acc_byte, acc_mis;
   logic [ADDR_BITS+1:0]   acc_addr;
   logic [ADDR_BITS-1:0]   acc_idx;
   logic [1:0]             acc_lane;
   logic [31:0]            rd_word, load_data;
   logic [7:0]             rd_byte;
   logic                   unused_addr_bits;

   logic [31:0]            mem [DEPTH];

   assign unused_addr_bits = ^AddrM[31:ADDR_BITS+2];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      finish    = 1'b0;
      CStall    = 1'b0;
      RValid    = 1'b0;
      case (state)
         S_IDLE: begin
            if (ReqM) begin
               accept = 1'b1;
               CStall = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = S_DONE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = S_BUSY;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         S_BUSY: begin
            CStall = 1'b1;
            if (cnt == '0) begin
               state_nxt = S_DONE;
               finish    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_DONE: begin
            RValid    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // With LATENCY=1 the response is registered on the acceptance edge, so the live inputs feed the datapath in IDLE.
   assign acc_we   = (state == S_IDLE) ? WeM                   : we_q;
   assign acc_byte = (state == S_IDLE) ? ByteAddressM          : byte_q;
   assign acc_addr = (state == S_IDLE) ? AddrM[ADDR_BITS+1:0]  : addr_q;
   assign acc_idx  = acc_addr[ADDR_BITS+1:2];
   assign acc_lane = acc_addr[1:0];

`ifdef DMEM_MISALIGN_EN
   assign acc_mis     = !acc_byte && (acc_lane != 2'b00);
   assign MisalignErr = (state == S_DONE) && mis_q;
`else
   assign acc_mis     = 1'b0;
   assign MisalignErr = 1'b0;
`endif

   assign rd_word   = mem[acc_idx];
   assign rd_byte   = rd_word[acc_lane*8 +: 8];
   assign load_data = acc_mis  ? 32'h0 :
                      acc_byte ? {24'h0, rd_byte} : rd_word;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         mis_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         RDataW  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we_q    <= WeM;
            byte_q  <= ByteAddressM;
            mis_q   <= acc_mis;
            addr_q  <= AddrM[ADDR_BITS+1:0];
            wdata_q <= WDataM;
         end
         // Store responses keep the previous read data unless the access was rejected as misaligned.
         if (finish && (!acc_we || acc_mis))
            RDataW <= load_data;
      end
   end

   // Array is deliberately not reset; reset only returns the FSM to IDLE, which blocks any pending commit.
   always_ff @(posedge clk) begin
      if ((state == S_DONE) && we_q && !mis_q) begin
         if (byte_q)
            mem[addr_q[ADDR_BITS+1:2]][addr_q[1:0]*8 +: 8] <= wdata_q[7:0];
         else
            mem[addr_q[ADDR_BITS+1:2]] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 and a LATENCY=1 instance checked against a reference memory model
// through a scoreboard of expected responses.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic        bya   [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        cstall[2];
   logic        rvalid[2];
   logic        merr  [2];
   logic [31:0] rdata [2];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl     [2][1024];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(3), .ADDR_BITS(10)) u_dut0 (
      .clk(clk), .rst(rst), .ReqM(req[0]), .WeM(we[0]), .ByteAddressM(bya[0]),
      .AddrM(addr[0]), .WDataM(wdata[0]), .CStall(cstall[0]), .RValid(rvalid[0]),
      .RDataW(rdata[0]), .MisalignErr(merr[0])
   );

   dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_dut1 (
      .clk(clk), .rst(rst), .ReqM(req[1]), .WeM(we[1]), .ByteAddressM(bya[1]),
      .AddrM(addr[1]), .WDataM(wdata[1]), .CStall(cstall[1]), .RValid(rvalid[1]),
      .RDataW(rdata[1]), .MisalignErr(merr[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic access(input int d, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
      exp_t e;
      exp_t got_e;
      int   idx;
      int   lane;
      bit   mis;
      int   stalls;
      int   rv_cyc;
      idx  = int'(a[11:2]);
      lane = int'(a[1:0]);
      mis  = 1'b0;
`ifdef DMEM_MISALIGN_EN
      mis  = !b && (a[1:0] != 2'b00);
`endif
      if (mis) begin
         e.rdata = 32'h0;
      end else if (w) begin
         if (b) mdl[d][idx][lane*8 +: 8] = wd[7:0];
         else   mdl[d][idx] = wd;
         e.rdata = last_rd[d];
      end else begin
         e.rdata = b ? {24'h0, mdl[d][idx][lane*8 +: 8]} : mdl[d][idx];
      end
      e.err      = mis;
      last_rd[d] = e.rdata;
      sb.push_back(e);

      @(negedge clk);
      req[d] = 1'b1; we[d] = w; bya[d] = b; addr[d] = a; wdata[d] = wd;
      stalls = 0;
      rv_cyc = 0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (k == 1) check_val({tag, "_rv_idle"}, 32'(rvalid[d]), 32'h0);
         if (rvalid[d]) begin
            rv_cyc = k;
            break;
         end
         if (cstall[d]) stalls++;
         @(posedge clk);
         #1;
         // Scramble the request fields after acceptance; the access must use the latched copy.
         req[d] = 1'b0; we[d] = ~w; bya[d] = ~b; addr[d] = ~a; wdata[d] = ~wd;
         @(negedge clk);
      end
      got_e = sb.pop_front();
      if (rv_cyc == 0) begin
         check_val({tag, "_timeout"}, 32'h0, 32'h1);
      end else begin
         check_val({tag, "_stall"}, 32'(stalls), 32'(lat_of(d)));
         check_val({tag, "_rv_cyc"}, 32'(rv_cyc), 32'(lat_of(d) + 1));
         check_val({tag, "_cstall_done"}, 32'(cstall[d]), 32'h0);
         check_val({tag, "_rdata"}, rdata[d], got_e.rdata);
         check_val({tag, "_merr"}, 32'(merr[d]), 32'(got_e.err));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; bya[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
         last_rd[d] = '0;
      end
      #1;
      check_val("rst_rvalid", 32'(rvalid[0]), 32'h0);
      check_val("rst_rdata",  rdata[0], 32'h0);
      check_val("rst_cstall", 32'(cstall[0]), 32'h0);
      check_val("rst_merr",   32'(merr[0]), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "st_word");
      access(0, 1'b0, 1'b0, 32'h10, 32'h0,        "ld_word");
      check_val("ld_word_const", rdata[0], 32'hDEADBEEF);
      access(0, 1'b1, 1'b1, 32'h13, 32'h000000AB, "st_byte");
      access(0, 1'b0, 1'b0, 32'h10, 32'h0,        "ld_lanes");
      check_val("ld_lanes_const", rdata[0], 32'hABADBEEF);
      access(0, 1'b0, 1'b1, 32'h11, 32'h0,        "ld_byte");
      check_val("ld_byte_const", rdata[0], 32'h000000BE);

      // Abort a store while BUSY: outputs clear and the array keeps the old word.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; bya[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'h11111111;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("midrst_rvalid", 32'(rvalid[0]), 32'h0);
      check_val("midrst_rdata",  rdata[0], 32'h0);
      check_val("midrst_cstall", 32'(cstall[0]), 32'h0);
      check_val("midrst_rdata1", rdata[1], 32'h0);
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      rst = 1'b1;
      access(0, 1'b0, 1'b0, 32'h10, 32'h0, "ld_after_rst");
      check_val("ld_after_rst_const", rdata[0], 32'hABADBEEF);

      access(0, 1'b0, 1'b0, 32'h12, 32'h0, "misalign");

      access(1, 1'b1, 1'b0, 32'h1010, 32'h5, "l1_st_wrap");
      access(1, 1'b0, 1'b0, 32'h10,   32'h0, "l1_ld_wrap");
      check_val("l1_ld_wrap_const", rdata[1], 32'h5);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++)
            access(d, 1'b1, 1'b0, 32'h100 + 32'(i * 4), $urandom, "rnd_init");
         for (int i = 0; i < 16; i++) begin
            ra = 32'h100 + 32'($urandom_range(0, 31)) + {18'h0, 2'($urandom_range(0, 3)), 12'h0};
            access(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, "rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
